// File: rtl/spi_xfer_engine_if.sv
// spi_xfer_engine_if: groups the FIFO, SPI and status signals of spi_xfer_engine.
// Latency: none, this is wiring only.
// Backpressure: carried by tx_empty_i / rx_full_i, which the engine observes.
interface spi_xfer_engine_if #(
  parameter int g_width = 32
);
  logic               clr_i;
  logic               en_i;
  logic [g_width-1:0] tx_data_i;
  logic               tx_empty_i;
  logic               tx_pull_o;
  logic [g_width-1:0] rx_data_o;
  logic               rx_full_i;
  logic               rx_push_o;
  logic               sck_o;
  logic               mosi_o;
  logic               miso_i;
  logic               ss_n_o;
  logic               busy_o;
  logic               rx_ovr_o;

  // Engine side
  modport master (
    input  clr_i, en_i, tx_data_i, tx_empty_i, rx_full_i, miso_i,
    output tx_pull_o, rx_data_o, rx_push_o, sck_o, mosi_o, ss_n_o, busy_o, rx_ovr_o
  );

  // FIFO / SPI device side
  modport slave (
    output clr_i, en_i, tx_data_i, tx_empty_i, rx_full_i, miso_i,
    input  tx_pull_o, rx_data_o, rx_push_o, sck_o, mosi_o, ss_n_o, busy_o, rx_ovr_o
  );
endinterface

// File: rtl/spi_xfer_engine.sv
// spi_xfer_engine: SPI mode-0 master moving one word per transfer from a TX FIFO to an RX FIFO (define SPI_LSB_FIRST_EN for LSB-first order).
// Latency: rx_push_o fires (2*g_width+1)*g_clk_div+1 cycles after the tx_pull_o cycle.
// Backpressure: no transfer starts while rx_full_i is high; a full RX FIFO at word end drops the word and sets rx_ovr_o.
module spi_xfer_engine #(
  parameter int g_width   = 32,
  parameter int g_clk_div = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  spi_xfer_engine_if.master bus
);

  localparam int DIV_W  = (g_clk_div > 1) ? $clog2(g_clk_div) : 1;
  localparam int EDGE_W = $clog2(2 * g_width);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(g_clk_div - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * g_width - 1);
`ifdef SPI_LSB_FIRST_EN
  localparam int TX_BIT = 0;
`else
  localparam int TX_BIT = g_width - 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [EDGE_W-1:0]   edge_q;
  logic                sck_q;
  logic                smp_q;
  logic [g_width-1:0]  shreg_q;
  logic [g_width-1:0]  shift_nxt;
  logic [g_width-1:0]  rx_q;
  logic                ovr_q;
  logic                start;
  logic                div_tick;
  logic                last_edge;
  logic                on_wire;

  assign div_tick  = (div_q == DIV_LAST);
  assign last_edge = (edge_q == EDGE_LAST);
  assign on_wire   = (state_q == S_LOAD) || (state_q == S_SHIFT);

  // The bit sampled on the rising edge enters the register on the following
  // falling edge, so MOSI only ever moves while SCK falls.
`ifdef SPI_LSB_FIRST_EN
  assign shift_nxt = {smp_q, shreg_q[g_width-1:1]};
`else
  assign shift_nxt = {shreg_q[g_width-2:0], smp_q};
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and start decision
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en_i && !bus.tx_empty_i && !bus.rx_full_i) begin
          start   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (div_tick) begin
          state_d = S_LOAD == S_LOAD ? S_SHIFT : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_tick && last_edge) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Divider, SCK generation, shift register and received-word capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= '0;
      edge_q  <= '0;
      sck_q   <= 1'b0;
      smp_q   <= 1'b0;
      shreg_q <= '0;
      rx_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          div_q  <= '0;
          edge_q <= '0;
          sck_q  <= 1'b0;
          if (start) begin
            shreg_q <= bus.tx_data_i;
          end
        end
        S_LOAD: begin
          div_q <= div_tick ? '0 : div_q + DIV_W'(1);
        end
        S_SHIFT: begin
          if (div_tick) begin
            div_q  <= '0;
            sck_q  <= ~sck_q;
            edge_q <= edge_q + EDGE_W'(1);
            if (!sck_q) begin
              smp_q <= bus.miso_i;
            end else begin
              shreg_q <= shift_nxt;
              if (last_edge) begin
                rx_q <= shift_nxt;
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          div_q <= '0;
        end
      endcase
    end
  end

  // Sticky overrun flag; clear wins over a simultaneous overrun
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clr_i) begin
      ovr_q <= 1'b0;
    end else if ((state_q == S_DONE) && bus.rx_full_i) begin
      ovr_q <= 1'b1;
    end
  end

  assign bus.tx_pull_o = start & ~rst_i;
  assign bus.rx_push_o = (state_q == S_DONE) & ~bus.rx_full_i & ~rst_i;
  assign bus.ss_n_o    = ~on_wire;
  assign bus.busy_o    = (state_q != S_IDLE);
  assign bus.sck_o     = sck_q;
  assign bus.mosi_o    = on_wire ? shreg_q[TX_BIT] : 1'b0;
  assign bus.rx_data_o = rx_q;
  assign bus.rx_ovr_o  = ovr_q;

endmodule
